// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared definitions for the TM1638 panel arbiter.
//   - FSM state encodings for tm1638_arbiter.
//   - TM1638 command bytes for clients that build panel transactions.
//   - Helper that forms a display-control command from a brightness value.
package tm1638_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_GAP       = 3'd1;
    localparam state_t ST_OWN       = 3'd2;
    localparam state_t ST_LATCH     = 3'd3;
    localparam state_t ST_WAIT_RISE = 3'd4;
    localparam state_t ST_WAIT_FALL = 3'd5;

    localparam logic [7:0] TM_CMD_READ_KEYS  = 8'h42;
    localparam logic [7:0] TM_CMD_WRITE_AUTO = 8'h40;
    localparam logic [7:0] TM_CMD_ADDR       = 8'hC0;
    localparam logic [7:0] TM_CMD_DISP_CTRL  = 8'h80;

    function automatic logic [7:0] tm_disp_ctrl(input logic [3:0] brightness);
        return TM_CMD_DISP_CTRL | {4'h0, brightness};
    endfunction

endpackage

// File: rtl/tm1638_arbiter_if.sv
// tm1638_arbiter_if: one client's connection to the panel arbiter.
//   master (client side): drives req, valid, rd, wdata; sees gnt, ready, rdata, rvalid.
//   slave (arbiter side): the mirror image.
//   req    - client wants the panel for a whole transaction
//   gnt    - client owns the panel (chip select low)
//   valid  - byte request, honoured only while gnt
//   rd     - 1 = read byte, 0 = write wdata
//   ready  - one-cycle pulse, byte accepted
//   rdata  - last byte read for this client
//   rvalid - one-cycle pulse, byte complete
interface tm1638_arbiter_if;
    logic       req;
    logic       gnt;
    logic       valid;
    logic       rd;
    logic [7:0] wdata;
    logic       ready;
    logic [7:0] rdata;
    logic       rvalid;

    modport master (output req, valid, rd, wdata,
                    input  gnt, ready, rdata, rvalid);
    modport slave  (input  req, valid, rd, wdata,
                    output gnt, ready, rdata, rvalid);
endinterface

// File: rtl/tm1638_rr_pick.sv
// tm1638_rr_pick: two-way round-robin pointer.
//   clk, rst  - clock, synchronous active-high reset
//   req0_i/1_i - client requests
//   take_i    - the current pick is being granted this cycle
//   any_o     - at least one client requests
//   pick_o    - winning client (0/1); on a tie the client not served last wins
// After reset client 1 counts as last served, so client 0 wins the first tie.
module tm1638_rr_pick
    import tm1638_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    input  logic take_i,
    output logic any_o,
    output logic pick_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        any_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            pick_o = ~last_q;
        end else begin
            pick_o = req1_i;
        end
        last_d = take_i ? pick_o : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/tm1638_arbiter.sv
// tm1638_arbiter: shares one TM1638 byte engine between two clients.
//   clk, rst   - clock, synchronous active-high reset
//   c0, c1     - client ports (tm1638_arbiter_if.slave)
//   tm_cs      - panel chip select, active low, low while a grant is held
//   eng_latch  - one-cycle start pulse to the byte engine
//   eng_rw     - 1 = engine writes DIO, 0 = engine reads DIO
//   eng_wdata  - byte to the engine, held from latch until busy falls
//   eng_rdata  - byte from the engine, valid the cycle busy falls
//   eng_busy   - engine busy flag
//   timeout    - one-cycle pulse when an idle holder loses its grant
// All outputs come straight from registers.
module tm1638_arbiter
    import tm1638_pkg::*;
#(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    tm1638_arbiter_if.slave         c0,
    tm1638_arbiter_if.slave         c1,
    output logic                    tm_cs,
    output logic                    eng_latch,
    output logic                    eng_rw,
    output logic [7:0]              eng_wdata,
    input  logic [7:0]              eng_rdata,
    input  logic                    eng_busy,
    output logic                    timeout
);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             cs_q, cs_d;
    logic             latch_q, latch_d;
    logic             rw_q, rw_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             rd_q, rd_d;
    logic [1:0]       ready_q, ready_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [7:0]       rdata0_q, rdata0_d;
    logic [7:0]       rdata1_q, rdata1_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       any_req;
    logic       pick;
    logic       take;
    logic       h_req, h_valid, h_rd;
    logic [7:0] h_wdata;

    // Arbitration waits out an engine still busy from before a reset.
    assign take = (state_q == ST_IDLE) && any_req && !eng_busy;

    tm1638_rr_pick u_pick (
        .clk    (clk),
        .rst    (rst),
        .req0_i (c0.req),
        .req1_i (c1.req),
        .take_i (take),
        .any_o  (any_req),
        .pick_o (pick)
    );

    // Signals of whichever client currently owns the panel.
    assign h_req   = owner_q ? c1.req   : c0.req;
    assign h_valid = owner_q ? c1.valid : c0.valid;
    assign h_rd    = owner_q ? c1.rd    : c0.rd;
    assign h_wdata = owner_q ? c1.wdata : c0.wdata;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        gnt_d     = gnt_q;
        cs_d      = cs_q;
        latch_d   = 1'b0;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        ready_d   = 2'b00;
        rvalid_d  = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    owner_d = pick;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    cs_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!h_req) begin
                    gnt_d   = 2'b00;
                    cs_d    = 1'b1;
                    rw_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else if (h_valid) begin
                    ready_d[owner_q] = 1'b1;
                    rd_d    = h_rd;
                    rw_d    = ~h_rd;
                    wdata_d = h_wdata;
                    latch_d = 1'b1;
                    state_d = ST_LATCH;
                end else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    gnt_d     = 2'b00;
                    cs_d      = 1'b1;
                    rw_d      = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LATCH: begin
                state_d = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (eng_busy) begin
                    state_d = ST_WAIT_FALL;
                end
            end
            ST_WAIT_FALL: begin
                if (!eng_busy) begin
                    if (rd_q) begin
                        if (owner_q) begin
                            rdata1_d = eng_rdata;
                        end else begin
                            rdata0_d = eng_rdata;
                        end
                    end
                    rvalid_d[owner_q] = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_OWN;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            gnt_q     <= 2'b00;
            cs_q      <= 1'b1;
            latch_q   <= 1'b0;
            rw_q      <= 1'b1;
            wdata_q   <= 8'h00;
            rd_q      <= 1'b0;
            ready_q   <= 2'b00;
            rvalid_q  <= 2'b00;
            rdata0_q  <= 8'h00;
            rdata1_q  <= 8'h00;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            cs_q      <= cs_d;
            latch_q   <= latch_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign c0.gnt    = gnt_q[0];
    assign c1.gnt    = gnt_q[1];
    assign c0.ready  = ready_q[0];
    assign c1.ready  = ready_q[1];
    assign c0.rvalid = rvalid_q[0];
    assign c1.rvalid = rvalid_q[1];
    assign c0.rdata  = rdata0_q;
    assign c1.rdata  = rdata1_q;
    assign tm_cs     = cs_q;
    assign eng_latch = latch_q;
    assign eng_rw    = rw_q;
    assign eng_wdata = wdata_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_tm1638_arbiter.sv
// Testbench for tm1638_arbiter: directed client transactions against a
// behavioural byte engine; expected events are queued by the stimulus and
// matched by a monitor as the DUT produces them.
module tb_tm1638_arbiter;
    localparam int GAP = 4;
    localparam int TOC = 8;

    localparam int EV_GNT = 1;
    localparam int EV_RDY = 2;
    localparam int EV_LAT = 3;
    localparam int EV_RV  = 4;
    localparam int EV_TO  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tm_cs, eng_latch, eng_rw, timeout;
    logic [7:0] eng_wdata;
    logic [7:0] eng_rdata = 8'h00;
    logic       eng_busy  = 1'b0;

    always #5 clk = ~clk;

    tm1638_arbiter_if c0_if ();
    tm1638_arbiter_if c1_if ();

    tm1638_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOC), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .c0        (c0_if.slave),
        .c1        (c1_if.slave),
        .tm_cs     (tm_cs),
        .eng_latch (eng_latch),
        .eng_rw    (eng_rw),
        .eng_wdata (eng_wdata),
        .eng_rdata (eng_rdata),
        .eng_busy  (eng_busy),
        .timeout   (timeout)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_q[$];
    int         eng_len  = 3;
    logic [7:0] eng_resp = 8'h00;
    logic [7:0] exp_rdata [2] = '{8'h00, 8'h00};

    function automatic int ev(input int t, input int c, input int d);
        return (t << 24) | ((c & 8'hFF) << 16) | (d & 16'hFFFF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic g_gnt(input int c);
        return (c == 0) ? c0_if.gnt : c1_if.gnt;
    endfunction
    function automatic logic g_ready(input int c);
        return (c == 0) ? c0_if.ready : c1_if.ready;
    endfunction
    function automatic logic g_rvalid(input int c);
        return (c == 0) ? c0_if.rvalid : c1_if.rvalid;
    endfunction
    function automatic logic [7:0] g_rdata(input int c);
        return (c == 0) ? c0_if.rdata : c1_if.rdata;
    endfunction

    task automatic set_req(input int c, input logic v);
        if (c == 0) c0_if.req = v; else c1_if.req = v;
    endtask

    task automatic set_valid(input int c, input logic v, input logic rd, input logic [7:0] wd);
        if (c == 0) begin
            c0_if.valid = v; c0_if.rd = rd; c0_if.wdata = wd;
        end else begin
            c1_if.valid = v; c1_if.rd = rd; c1_if.wdata = wd;
        end
    endtask

    // Byte engine: busy rises the cycle after latch, stays up eng_len cycles,
    // and presents the response byte as it falls. It ignores rst.
    initial begin
        forever begin
            @(negedge clk);
            if (eng_latch) begin
                @(posedge clk); #1;
                eng_busy = 1'b1;
                repeat (eng_len) @(posedge clk);
                #1;
                eng_rdata = eng_resp;
                eng_busy  = 1'b0;
            end
        end
    end

    // Scoreboard monitor
    logic [1:0] prev_gnt = 2'b00;
    logic       prev_cs  = 1'b1;
    bit         track    = 1'b0;
    bit         pending  = 1'b0;
    int         hi_cnt   = 0;

    task automatic sb(input int got);
        int e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got event %08h, none expected at %0t", got, $time);
        end else begin
            e = exp_q.pop_front();
            if (e != got) begin
                n_fail++;
                $display("FAIL sb_event: got %08h expected %08h at %0t", got, e, $time);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            track = 1'b0;
        end else begin
            check("cs_vs_gnt", {31'd0, tm_cs}, {31'd0, !(c0_if.gnt || c1_if.gnt)});
            if (tm_cs && !prev_cs) begin
                check("cs_rise_busy", {31'd0, eng_busy}, 32'd0);
                track   = 1'b1;
                hi_cnt  = 1;
                pending = c0_if.req || c1_if.req;
            end else if (tm_cs && track) begin
                hi_cnt++;
            end
            if (!tm_cs && prev_cs && track) begin
                if (pending) check("cs_gap", hi_cnt, GAP + 1);
                else         check("cs_gap_min", {31'd0, hi_cnt >= GAP + 1}, 32'd1);
            end
            for (int c = 0; c < 2; c++)
                if (g_gnt(c) && !prev_gnt[c]) sb(ev(EV_GNT, c, 0));
            for (int c = 0; c < 2; c++)
                if (g_ready(c)) sb(ev(EV_RDY, c, 0));
            if (eng_latch) sb(ev(EV_LAT, int'(eng_rw), int'(eng_wdata)));
            for (int c = 0; c < 2; c++)
                if (g_rvalid(c)) sb(ev(EV_RV, c, int'(g_rdata(c))));
            if (timeout) sb(ev(EV_TO, 0, 0));
        end
        prev_gnt = {c1_if.gnt, c0_if.gnt};
        prev_cs  = tm_cs;
    end

    task automatic check_reset_vals();
        check("rst_gnt0",    {31'd0, c0_if.gnt},    32'd0);
        check("rst_gnt1",    {31'd0, c1_if.gnt},    32'd0);
        check("rst_ready0",  {31'd0, c0_if.ready},  32'd0);
        check("rst_ready1",  {31'd0, c1_if.ready},  32'd0);
        check("rst_rvalid0", {31'd0, c0_if.rvalid}, 32'd0);
        check("rst_rvalid1", {31'd0, c1_if.rvalid}, 32'd0);
        check("rst_rdata0",  {24'd0, c0_if.rdata},  32'd0);
        check("rst_rdata1",  {24'd0, c1_if.rdata},  32'd0);
        check("rst_tm_cs",   {31'd0, tm_cs},        32'd1);
        check("rst_latch",   {31'd0, eng_latch},    32'd0);
        check("rst_rw",      {31'd0, eng_rw},       32'd1);
        check("rst_wdata",   {24'd0, eng_wdata},    32'd0);
        check("rst_timeout", {31'd0, timeout},      32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
    endtask

    task automatic wait_gnt(input int c);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!g_gnt(c) && k < 100);
        check($sformatf("gnt_wait_c%0d", c), {31'd0, g_gnt(c)}, 32'd1);
    endtask

    task automatic wait_ready(input int c);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!g_ready(c) && k < 20);
        check($sformatf("ready_wait_c%0d", c), {31'd0, g_ready(c)}, 32'd1);
    endtask

    // One byte by client c; optionally drops req right after acceptance.
    task automatic do_byte(input int c, input logic rd, input logic [7:0] wd,
                           input logic [7:0] resp, input bit drop);
        int k = 0;
        exp_q.push_back(ev(EV_RDY, c, 0));
        exp_q.push_back(ev(EV_LAT, rd ? 0 : 1, int'(wd)));
        if (rd) exp_rdata[c] = resp;
        exp_q.push_back(ev(EV_RV, c, int'(exp_rdata[c])));
        eng_resp = resp;
        @(posedge clk); #1;
        set_valid(c, 1'b1, rd, wd);
        wait_ready(c);
        @(posedge clk); #1;
        set_valid(c, 1'b0, 1'b0, 8'h00);
        if (drop) set_req(c, 1'b0);
        do begin
            @(negedge clk);
            k++;
            if (!g_rvalid(c)) check("cs_low_mid_byte", {31'd0, tm_cs}, 32'd0);
        end while (!g_rvalid(c) && k < 50);
        check($sformatf("rvalid_wait_c%0d", c), {31'd0, g_rvalid(c)}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        c0_if.req = 0; c0_if.valid = 0; c0_if.rd = 0; c0_if.wdata = 0;
        c1_if.req = 0; c1_if.valid = 0; c1_if.rd = 0; c1_if.wdata = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        rst = 1'b0;

        // Single write from c0
        exp_q.push_back(ev(EV_GNT, 0, 0));
        @(posedge clk); #1;
        set_req(0, 1'b1);
        wait_gnt(0);
        do_byte(0, 1'b0, 8'h40, 8'h00, 1'b0);
        @(posedge clk); #1;
        set_req(0, 1'b0);
        repeat (3) @(negedge clk);
        check("write_cs_high", {31'd0, tm_cs}, 32'd1);
        repeat (6) @(posedge clk);

        // c1: write 0x42 command, then read a byte returning 0xA5
        exp_q.push_back(ev(EV_GNT, 1, 0));
        @(posedge clk); #1;
        set_req(1, 1'b1);
        wait_gnt(1);
        do_byte(1, 1'b0, 8'h42, 8'h00, 1'b0);
        do_byte(1, 1'b1, 8'h00, 8'hA5, 1'b0);
        check("read_rdata1", {24'd0, c1_if.rdata}, 32'h000000A5);
        check("read_rdata0_kept", {24'd0, c0_if.rdata}, 32'd0);
        @(posedge clk); #1;
        set_req(1, 1'b0);
        repeat (8) @(posedge clk);

        // Contention from reset: c0 first, c1 after the gap, c0 re-request waits
        do_reset();
        exp_q.push_back(ev(EV_GNT, 0, 0));
        @(posedge clk); #1;
        set_req(0, 1'b1);
        set_req(1, 1'b1);
        wait_gnt(0);
        check("cont_c1_not_granted", {31'd0, c1_if.gnt}, 32'd0);
        @(posedge clk); #1;
        set_valid(1, 1'b1, 1'b1, 8'h55);
        do_byte(0, 1'b0, 8'hC0, 8'h00, 1'b0);
        @(posedge clk); #1;
        set_valid(1, 1'b0, 1'b0, 8'h00);
        check("cont_c1_rdata_kept", {24'd0, c1_if.rdata}, 32'd0);
        exp_q.push_back(ev(EV_GNT, 1, 0));
        set_req(0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        set_req(0, 1'b1);
        wait_gnt(1);
        do_byte(1, 1'b0, 8'h8F, 8'h00, 1'b0);
        exp_q.push_back(ev(EV_GNT, 0, 0));
        @(posedge clk); #1;
        set_req(1, 1'b0);
        wait_gnt(0);
        @(posedge clk); #1;
        set_req(0, 1'b0);
        repeat (8) @(posedge clk);

        // Req dropped mid-byte: CS held low until the byte completes
        eng_len = 6;
        exp_q.push_back(ev(EV_GNT, 0, 0));
        @(posedge clk); #1;
        set_req(0, 1'b1);
        wait_gnt(0);
        do_byte(0, 1'b0, 8'h11, 8'h00, 1'b1);
        repeat (2) @(negedge clk);
        check("drop_cs_high", {31'd0, tm_cs}, 32'd1);
        check("drop_gnt_low", {31'd0, c0_if.gnt}, 32'd0);
        repeat (8) @(posedge clk);

        // rst during WAIT_FALL; no grant until the engine finishes
        eng_len = 10;
        exp_q.push_back(ev(EV_GNT, 0, 0));
        exp_q.push_back(ev(EV_RDY, 0, 0));
        exp_q.push_back(ev(EV_LAT, 1, 8'h22));
        @(posedge clk); #1;
        set_req(0, 1'b1);
        wait_gnt(0);
        @(posedge clk); #1;
        set_valid(0, 1'b1, 1'b0, 8'h22);
        wait_ready(0);
        @(posedge clk); #1;
        set_valid(0, 1'b0, 1'b0, 8'h00);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!eng_busy && k < 20);
        check("rst_busy_seen", {31'd0, eng_busy}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.push_back(ev(EV_GNT, 0, 0));
        @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        k = 0;
        while (eng_busy && k < 50) begin
            @(negedge clk);
            k++;
            if (eng_busy) check("no_gnt_while_busy", {31'd0, c0_if.gnt}, 32'd0);
        end
        wait_gnt(0);
        check("gnt_after_busy_low", {31'd0, eng_busy}, 32'd0);
        @(posedge clk); #1;
        set_req(0, 1'b0);
        eng_len = 3;
        repeat (8) @(posedge clk);

        // Watchdog: c0 idles after grant, c1 served after the forced release
        do_reset();
        exp_q.push_back(ev(EV_GNT, 0, 0));
        exp_q.push_back(ev(EV_TO, 0, 0));
        exp_q.push_back(ev(EV_GNT, 1, 0));
        @(posedge clk); #1;
        set_req(0, 1'b1);
        set_req(1, 1'b1);
        wait_gnt(0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!timeout && k < 50);
        check("wd_timeout_cycle", k, TOC);
        check("wd_gnt0_dropped", {31'd0, c0_if.gnt}, 32'd0);
        check("wd_cs_high", {31'd0, tm_cs}, 32'd1);
        @(posedge clk); #1;
        set_req(0, 1'b0);
        wait_gnt(1);
        do_byte(1, 1'b0, 8'h88, 8'h00, 1'b0);
        @(posedge clk); #1;
        set_req(1, 1'b0);

        repeat (20) @(posedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
